fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Write-side arbiter for the asynchronous FIFO: it shares the single FIFO write port among NUM_REQ requesters in the write clock domain. Requesters present words on valid/ready handshakes, and the block selects one round-robin. Multi-word packets delimited by req_last hold the grant until the packet completes. The chosen word is registered and driven onto winc/wdata under wfull back-pressure.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- DSIZE, 8, data width; equals FIFO DSIZE
- IDW, $clog2(NUM_REQ), width of source-ID output
- clk  in  1  write-domain clock
- rst_n  in  1  reset rst_n, asynchronous, active-low; clock clk
- req_valid  in  NUM_REQ  per-requester word valid
- req_last  in  NUM_REQ  per-requester last-word-of-packet flag, qualified by req_valid
- req_data  in  NUM_REQ*DSIZE  requester i occupies bits [i*DSIZE +: DSIZE]
- req_ready  out  NUM_REQ  one-hot or zero; word i accepted when req_valid[i] && req_ready[i]
- wfull  in  1  FIFO full flag, write domain
- winc  out  1  FIFO write enable
- wdata  out  DSIZE  FIFO write data
- wid  out  IDW  source index of the word on wdata
- locked  out  1  packet lock in progress

## Operation
- Output stage is one register: out_valid, wdata, wid.
- winc = out_valid && !wfull. This is combinational from registers and wfull only.
- load = !out_valid || winc: the stage can take a word this cycle.
- State machine:
  - IDLE: candidates are all req_valid bits. The winner is the first set bit searching upward from (ptr+1) mod NUM_REQ.
  - LOCK: the only candidate is lock_id.
- req_ready[i] = load && candidate winner == i. Never more than one bit set. req_ready does not depend on req_ready.
- On accept of word from i:
  - wdata <= req_data[i], wid <= i, out_valid <= 1, ptr <= i.
  - If req_last[i] = 0: state <= LOCK, lock_id <= i.
  - If req_last[i] = 1: state <= IDLE.
- If winc and no accept: out_valid <= 0.
- In LOCK with req_valid[lock_id] low:
  - No grant. Other requesters stall.
  - The lock persists and there is no timeout.
- The round-robin pointer advances only on accept. A locked packet counts as one arbitration win.
- Reset values: out_valid 0, winc 0, wdata 0, wid 0, req_ready 0, locked 0, state IDLE, ptr NUM_REQ-1 (requester 0 has first priority).
- Reset mid-packet drops the lock and any held word. No partial-packet recovery.

## Timing
- Accept at edge n puts the word on wdata/wid after edge n. winc is asserted in cycle n+1 if wfull is 0.
- Sustained throughput is 1 word/cycle while wfull stays 0.
- When wfull = 1 with out_valid = 1:
  - winc = 0 and req_ready is all 0.
  - The held word is stable until wfull drops.
- wfull falling: winc is asserted in the same cycle, and a new word may be accepted in the same cycle (load = 1).
- Simultaneous winc and accept replaces the register contents with no bubble.
- Requester-side rule: req_data/req_last must be held while req_valid is high and ready is low.

## Structure
- Package fifo_arb_pkg holds:
  - state encoding constants ST_IDLE, ST_LOCK
  - the IDW computation helper
- Sub-module rr_pick (combinational):
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant and its index, using a doubled-vector priority search.
- The top level holds the FSM, pointer and output register.

## Test plan
- Reset, then req_valid=4'b1111 all last=1, wfull=0 → grants in order 0,1,2,3,0; one winc per cycle; wid 0,1,2,3,0.
- Requester 2 sends a 3-word packet A0,A1,A2 (last only on A2) while 1 and 3 are valid → wid sequence 2,2,2 then 3,0/1 in round-robin order; locked high for exactly the A0→A2 accept window.
- wfull=1 for 5 cycles with out_valid=1 and data 8'hA5 held → winc=0, req_ready=0, wdata stays 8'hA5; on wfull falling, winc=1 and the next word is accepted in the same cycle.
- Locked requester 1 drops req_valid for 4 cycles mid-packet while 0 and 2 are valid → no grants during the gap; packet resumes on wid=1.
- rst_n asserted asynchronously mid-packet with out_valid=1 → winc, req_ready, locked go 0 immediately; after release, requester 0 wins first.
- NUM_REQ=3, only requester 2 valid repeatedly → back-to-back grants to 2 every cycle, with pointer wrap handled correctly.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } arb_state_e;

   // Index width for n requesters; never below one bit.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request strictly after ptr, found via a doubled request vector.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDW     = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDW-1:0]     idx
);

   logic [2*NUM_REQ-1:0] dbl;
   int                   pos;

   // Walk from the farthest offset down so the nearest match after ptr is the one kept.
   always_comb begin
      dbl = {req, req};
      gnt = '0;
      idx = '0;
      pos = 0;
      for (int k = int'(NUM_REQ); k >= 1; k--) begin
         pos = int'(ptr) + k;
         if (pos < 2 * int'(NUM_REQ) && dbl[pos]) begin
            gnt                       = '0;
            gnt[pos % int'(NUM_REQ)]  = 1'b1;
            idx                       = IDW'(pos % int'(NUM_REQ));
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locking arbiter sharing one FIFO write port among NUM_REQ requesters.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DSIZE   = 8,
   parameter int unsigned IDW     = id_width(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ-1:0]       req_last,
   input  logic [NUM_REQ*DSIZE-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic                     wfull,
   output logic                     winc,
   output logic [DSIZE-1:0]         wdata,
   output logic [IDW-1:0]           wid,
   output logic                     locked
);

   arb_state_e           state_q, state_d;
   logic [IDW-1:0]       ptr_q, ptr_d;
   logic [IDW-1:0]       lock_id_q, lock_id_d;
   logic                 out_valid_q, out_valid_d;
   logic [DSIZE-1:0]     wdata_q, wdata_d;
   logic [IDW-1:0]       wid_q, wid_d;

   logic [NUM_REQ-1:0]   lock_mask;
   logic [NUM_REQ-1:0]   cand;
   logic [NUM_REQ-1:0]   gnt;
   logic [IDW-1:0]       gnt_idx;
   logic                 load;
   logic                 accept;
   logic [DSIZE-1:0]     sel_data;
   logic                 sel_last;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_rr_pick (
      .req (cand),
      .ptr (ptr_q),
      .gnt (gnt),
      .idx (gnt_idx)
   );

   always_comb begin
      lock_mask            = '0;
      lock_mask[lock_id_q] = 1'b1;
      cand      = (state_q == ST_LOCK) ? (req_valid & lock_mask) : req_valid;
      winc      = out_valid_q & ~wfull;
      // Gated by rst_n so no handshake can be offered while reset is held.
      load      = rst_n & (~out_valid_q | winc);
      req_ready = load ? gnt : '0;
      accept    = |req_ready;
      locked    = (state_q == ST_LOCK);
      wdata     = wdata_q;
      wid       = wid_q;
   end

   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (gnt[i]) begin
            sel_data = sel_data | req_data[i*DSIZE +: DSIZE];
            sel_last = sel_last | req_last[i];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      lock_id_d   = lock_id_q;
      out_valid_d = out_valid_q;
      wdata_d     = wdata_q;
      wid_d       = wid_q;
      if (accept) begin
         out_valid_d = 1'b1;
         wdata_d     = sel_data;
         wid_d       = gnt_idx;
         ptr_d       = gnt_idx;
         lock_id_d   = gnt_idx;
         state_d     = sel_last ? ST_IDLE : ST_LOCK;
      end else if (winc) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= IDW'(NUM_REQ - 1);
         lock_id_q   <= '0;
         out_valid_q <= 1'b0;
         wdata_q     <= '0;
         wid_q       <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         lock_id_q   <= lock_id_d;
         out_valid_q <= out_valid_d;
         wdata_q     <= wdata_d;
         wid_q       <= wid_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a cycle-level behavioural model.
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid = '0, req_last = '0, req_ready;
   logic [N*DW-1:0] req_data = '0;
   logic            wfull = 1'b0, winc, locked;
   logic [DW-1:0]   wdata;
   logic [1:0]      wid;

   logic [2:0]      rv3 = '0, rl3 = '0, rr3;
   logic [3*DW-1:0] rd3 = '0;
   logic            winc3, locked3;
   logic [DW-1:0]   wdata3;
   logic [1:0]      wid3;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model state
   bit           m_ov;
   logic [DW-1:0] m_wdata;
   int           m_wid, m_ptr, m_lock;
   logic [N-1:0] m_acc;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.NUM_REQ(N), .DSIZE(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_last  (req_last),
      .req_data  (req_data),
      .req_ready (req_ready),
      .wfull     (wfull),
      .winc      (winc),
      .wdata     (wdata),
      .wid       (wid),
      .locked    (locked)
   );

   fifo_wr_arbiter #(.NUM_REQ(3), .DSIZE(DW)) dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (rv3),
      .req_last  (rl3),
      .req_data  (rd3),
      .req_ready (rr3),
      .wfull     (1'b0),
      .winc      (winc3),
      .wdata     (wdata3),
      .wid       (wid3),
      .locked    (locked3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_ov = 0; m_wdata = '0; m_wid = 0; m_ptr = N - 1; m_lock = -1; m_acc = '0;
   endtask

   // Compare outputs for the current cycle, then advance the model past the coming edge.
   task automatic model_step();
      bit winc_e, load_e;
      int win;
      logic [N-1:0] rdy;
      winc_e = m_ov && !wfull;
      load_e = !m_ov || winc_e;
      win = -1;
      if (m_lock >= 0) begin
         if (req_valid[m_lock]) win = m_lock;
      end else begin
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (win < 0 && req_valid[c]) win = c;
         end
      end
      rdy = '0;
      if (load_e && win >= 0) rdy[win] = 1'b1;
      chk("winc", {31'b0, winc}, {31'b0, winc_e});
      chk("req_ready", {28'b0, req_ready}, {28'b0, rdy});
      chk("locked", {31'b0, locked}, {31'b0, m_lock >= 0});
      chk("wdata", {24'b0, wdata}, {24'b0, m_wdata});
      chk("wid", {30'b0, wid}, m_wid);
      m_acc = rdy & req_valid;
      if (load_e && win >= 0) begin
         m_ov = 1; m_wdata = req_data[win*DW +: DW]; m_wid = win; m_ptr = win;
         m_lock = req_last[win] ? -1 : win;
      end else if (winc_e) begin
         m_ov = 0;
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req_valid = '0; req_last = '0; wfull = 1'b0; rv3 = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      #1;
      chk("rst_winc", {31'b0, winc}, 0);
      chk("rst_locked", {31'b0, locked}, 0);
      chk("rst_wdata", {24'b0, wdata}, 0);
      chk("rst_wid", {30'b0, wid}, 0);
   endtask

   task automatic rand_update();
      for (int i = 0; i < N; i++) begin
         if (!(req_valid[i] && !m_acc[i])) begin
            req_valid[i] = ($urandom_range(0, 99) < 60);
            req_last[i]  = ($urandom_range(0, 1) == 1);
            req_data[i*DW +: DW] = DW'($urandom);
         end
      end
      wfull = ($urandom_range(0, 99) < 25);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      int lit_rr[5]  = '{0, 1, 2, 3, 0};
      int lit_pw[5]  = '{2, 2, 2, 3, 1};
      int lit_pl[5]  = '{1, 1, 0, 0, 0};
      int a;

      // Round robin with everyone valid, single-word packets
      do_reset();
      req_valid = 4'b1111; req_last = 4'b1111; req_data = 32'h44332211;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("rr_wid", {30'b0, wid}, lit_rr[k]);
      end

      // Three-word packet from requester 2 while 1 and 3 compete
      do_reset();
      req_valid = 4'b0010; req_last = 4'b0010; req_data[8 +: 8] = 8'h11;
      step();
      chk("pk_first_wid", {30'b0, wid}, 1);
      a = 0;
      req_valid = 4'b1110; req_last = 4'b1010;
      req_data[16 +: 8] = 8'hA0; req_data[24 +: 8] = 8'h33;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("pk_wid", {30'b0, wid}, lit_pw[k]);
         chk("pk_locked", {31'b0, locked}, lit_pl[k]);
         if (k < 3) chk("pk_wdata", {24'b0, wdata}, 32'hA0 + k);
         if (m_acc[2]) a++;
         req_data[16 +: 8] = 8'(8'hA0 + a);
         req_last[2]  = (a == 2);
         req_valid[2] = (a < 3);
      end

      // Back-pressure hold and release
      do_reset();
      req_valid = 4'b0001; req_last = 4'b0001; req_data = 32'h000000A5;
      step();
      chk("bp_load", {24'b0, wdata}, 32'hA5);
      req_valid = 4'b0110; req_last = 4'b0110; req_data = 32'h00C3B200;
      wfull = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_winc", {31'b0, winc}, 0);
         chk("bp_ready", {28'b0, req_ready}, 0);
         chk("bp_wdata", {24'b0, wdata}, 32'hA5);
         step();
      end
      wfull = 1'b0;
      #1;
      chk("bp_rel_winc", {31'b0, winc}, 1);
      chk("bp_rel_ready", {28'b0, req_ready}, 4'b0010);
      step();
      chk("bp_next_wid", {30'b0, wid}, 1);
      chk("bp_next_wdata", {24'b0, wdata}, 32'hB2);

      // Locked requester goes quiet; nobody else may slip in
      do_reset();
      req_valid = 4'b0010; req_last = 4'b0000; req_data = 32'h00001100;
      step();
      req_valid = 4'b0101; req_last = 4'b0101;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("gap_ready", {28'b0, req_ready}, 0);
         step();
      end
      req_valid = 4'b0111; req_last = 4'b0111; req_data[8 +: 8] = 8'h12;
      #1;
      chk("gap_resume_ready", {28'b0, req_ready}, 4'b0010);
      step();
      chk("gap_resume_wid", {30'b0, wid}, 1);
      chk("gap_resume_unlock", {31'b0, locked}, 0);

      // Asynchronous reset in the middle of a packet
      do_reset();
      req_valid = 4'b0010; req_last = 4'b0000; req_data = 32'h00005500;
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_winc", {31'b0, winc}, 0);
      chk("arst_ready", {28'b0, req_ready}, 0);
      chk("arst_locked", {31'b0, locked}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      req_valid = 4'b1111; req_last = 4'b1111;
      #1;
      chk("arst_first_ready", {28'b0, req_ready}, 4'b0001);
      step();
      chk("arst_first_wid", {30'b0, wid}, 0);

      // Three-requester instance, only requester 2 active
      do_reset();
      rv3 = 3'b100; rl3 = 3'b100;
      for (int k = 0; k < 6; k++) begin
         rd3[16 +: 8] = 8'(8'h30 + k);
         #1;
         chk("n3_ready", {29'b0, rr3}, 3'b100);
         chk("n3_winc", {31'b0, winc3}, (k > 0) ? 1 : 0);
         @(posedge clk);
         #1;
         chk("n3_wid", {30'b0, wid3}, 2);
         chk("n3_wdata", {24'b0, wdata3}, 32'h30 + k);
      end
      rv3 = '0;

      // Randomized traffic against the model
      do_reset();
      for (int k = 0; k < 400; k++) begin
         rand_update();
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
